mem_resp_multicycle: RTL

- Responder side of the CPU data/instruction memory interface. The pipelined core, or its cache controller, issues requests and this block answers them.
- Models a multi-cycle main memory with a fixed access latency and a one-outstanding-request handshake.
- Supports single-word read, single-word write and an aligned burst read for cache-line fill.
- Sits below the CPU memory stage and cache fill FSM; replaces the single-cycle memory models in the phase-3 build.

---
 rtl/mem_resp_pkg.sv | 24 ++
 rtl/mem_resp_multicycle_array.sv | 31 +++
 rtl/mem_resp_multicycle.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and default sizing for the multi-cycle memory
// responder.
//   state_e  : responder FSM state (IDLE/WAIT/RESP/BURST, 2-bit encoding)
//   DEF_*    : default parameter values used by mem_resp_multicycle
//   CNT_W    : width of the latency counter (covers LATENCY up to 15)
`timescale 1ns/1ps
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_DEPTH     = 32768;
  localparam int unsigned DEF_LATENCY   = 4;
  localparam int unsigned DEF_BURST_LEN = 8;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_resp_multicycle_array.sv
// mem_word_array: single-port word array, synchronous write, asynchronous
// read, no reset (contents survive rst_n).
//   clk      in  : write clock, rising edge
//   we_i     in  : write enable
//   idx_i    in  : word index (shared by read and write)
//   wdata_i  in  : write data
//   rdata_o  out : combinational read of mem_q[idx_i]
`timescale 1ns/1ps
module mem_word_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEF_DEPTH),
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_resp_multicycle.sv
// mem_resp_multicycle: responder for the CPU memory interface. Models a
// main memory with fixed access latency and one outstanding request.
// Supports single read, single write (committed on acceptance) and an
// aligned BURST_LEN-word burst read for cache-line fill.
//   clk, rst_n               : clock (rising) / async active-low reset
//   req_valid/req_ready      : request handshake; accepted when both high
//   req_wr, req_burst        : write / burst-read select (burst ignored on write)
//   req_addr, req_wdata      : byte address (bit 0 ignored), write data
//   resp_valid, resp_wr      : registered response strobe / write-ack flag
//   resp_addr, resp_rdata    : byte address of word, read data (0 unless read)
//   busy                     : inverse of req_ready
`timescale 1ns/1ps
module mem_resp_multicycle
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned LATENCY   = DEF_LATENCY,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_wr,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                wr_q, wr_d;
  logic                burst_q, burst_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_wr_q, resp_wr_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic                accept;
  logic [IDX_W-1:0]    req_idx;
  logic                cur_wr, cur_burst;
  logic [IDX_W-1:0]    cur_idx;
  logic [BEAT_W-1:0]   rd_beat;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_rdata;
  logic                addr_unused;

  // Word index mod DEPTH is just the low IDX_W bits above the byte bit.
  assign req_idx     = req_addr[IDX_W:1];
  assign addr_unused = req_addr[0] ^ (^(req_addr >> (IDX_W + 1)));

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && req_wr;

  // On the acceptance edge (LATENCY=1 path) the live request drives the
  // response; otherwise the latched copy does.
  assign cur_wr    = accept ? req_wr : wr_q;
  assign cur_burst = accept ? (req_burst && !req_wr) : burst_q;
  assign cur_idx   = accept ? req_idx : idx_q;

  // Array port: the word for the response being loaded this edge. In BURST
  // the next beat is read; entering a burst reads beat 0 of the block.
  assign rd_beat = (state_q == BURST) ? beat_q + BEAT_W'(1) : '0;
  assign mem_idx = cur_burst ? {cur_idx[IDX_W-1:BEAT_W], rd_beat} : cur_idx;

  mem_word_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (req_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    logic issue;
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    wr_d         = wr_q;
    burst_d      = burst_q;
    idx_d        = idx_q;
    resp_valid_d = 1'b0;
    resp_wr_d    = 1'b0;
    resp_addr_d  = resp_addr_q;
    resp_rdata_d = '0;
    issue        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_wr;
          burst_d = req_burst && !req_wr;
          idx_d   = req_idx;
          if (LATENCY == 1) begin
            issue = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // Leave when the decremented count reaches 0 so the first response
        // is registered LATENCY cycles after acceptance.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          issue = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      BURST: begin
        if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          beat_d       = rd_beat;
          resp_valid_d = 1'b1;
          resp_addr_d  = ADDR_W'({mem_idx, 1'b0});
          resp_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = ADDR_W'({mem_idx, 1'b0});
      if (cur_burst) begin
        state_d      = BURST;
        beat_d       = '0;
        resp_rdata_d = mem_rdata;
      end else begin
        state_d      = RESP;
        resp_wr_d    = cur_wr;
        resp_rdata_d = cur_wr ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      wr_q         <= 1'b0;
      burst_q      <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_wr_q    <= 1'b0;
      resp_addr_q  <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      wr_q         <= wr_d;
      burst_q      <= burst_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_wr_q    <= resp_wr_d;
      resp_addr_q  <= resp_addr_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_wr    = resp_wr_q;
  assign resp_addr  = resp_addr_q;
  assign resp_rdata = resp_rdata_q;

endmodule
